vga_timing_gen: RTL and testbench

//   VGA 640x480@60 timing generator and TinyVGA output stage for tt_um_gbellocchi_vga.

---
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - VGA timing generator signal bundle
//
// Purpose: groups the pixel-generator side signals of vga_timing_gen.
// Ports (signals):
//   ena        : count/update enable (slave -> master)
//   rgb[5:0]   : colour {R1,R0,G1,G0,B1,B0} for the current pixel (slave -> master)
//   hpos[9:0]  : current pixel column (master -> slave)
//   vpos[9:0]  : current line (master -> slave)
//   display_on : current pixel lies in the visible area
//   line_end   : current pixel is the last of its line
//   frame_end  : current pixel is the last of the frame
//   uo_out[7:0]: TinyVGA PMOD pins {hsync,B0,G0,R0,vsync,B1,G1,R1}
// The timing generator is the master; the pixel generator/consumer is the slave.
interface vga_timing_gen_if;
  logic       ena;
  logic [5:0] rgb;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       line_end;
  logic       frame_end;
  logic [7:0] uo_out;

  modport master (
    input  ena, rgb,
    output hpos, vpos, display_on, line_end, frame_end, uo_out
  );

  modport slave (
    output ena, rgb,
    input  hpos, vpos, display_on, line_end, frame_end, uo_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA 640x480@60 timing generator and TinyVGA output stage
//
// Purpose: counts pixel/line position, decodes visible area and line/frame strobes
// for the pixel generator, and registers blanked colour plus sync pulses onto the
// TinyVGA PMOD pin order.
// Ports:
//   clk    : pixel clock (25 MHz nominal)
//   rst_n  : asynchronous active-low reset
//   bus_io : vga_timing_gen_if.master (ena, rgb in; hpos, vpos, display_on,
//            line_end, frame_end, uo_out out)
// H_TOTAL and V_TOTAL must both be <= 1024 so the 10-bit counters can hold them.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_NEG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  bus_io
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Pin level when a sync pulse is not asserted.
  localparam logic SYNC_IDLE = (SYNC_NEG != 0);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [7:0] uo_q, uo_d;

  logic       h_last, v_last;
  logic       disp_on;
  logic       hs_act, vs_act;
  logic [5:0] rgb_vis;

  assign h_last  = (hpos_q == H_LAST);
  assign v_last  = (vpos_q == V_LAST);
  assign disp_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

  // vsync spans whole lines, so it depends on vpos only.
  assign hs_act  = (hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST);
  assign vs_act  = (vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST);
  assign rgb_vis = bus_io.rgb & {6{disp_on}};

  always_comb begin
    hpos_d = hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (h_last) begin
      hpos_d = '0;
      vpos_d = v_last ? '0 : (vpos_q + 10'd1);
    end
  end

  // TinyVGA pin order: {hsync,B0,G0,R0,vsync,B1,G1,R1}; rgb is {R1,R0,G1,G0,B1,B0}.
  always_comb begin
    uo_d = {hs_act ^ SYNC_IDLE, rgb_vis[0], rgb_vis[2], rgb_vis[4],
            vs_act ^ SYNC_IDLE, rgb_vis[1], rgb_vis[3], rgb_vis[5]};
  end

  // Colour and syncs are registered together from the same counter state, so the
  // pins lag hpos/vpos by one cycle but stay mutually aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q <= '0;
      vpos_q <= '0;
      uo_q   <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
    end else if (bus_io.ena) begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      uo_q   <= uo_d;
    end
  end

  // Strobes decode the held counters even when ena=0.
  assign bus_io.hpos       = hpos_q;
  assign bus_io.vpos       = vpos_q;
  assign bus_io.display_on = disp_on;
  assign bus_io.line_end   = h_last;
  assign bus_io.frame_end  = h_last && v_last;
  assign bus_io.uo_out     = uo_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if a ();
  vga_timing_gen_if b ();

  vga_timing_gen u_dut_a (
    .clk    (clk),
    .rst_n  (rst_a),
    .bus_io (a.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_NEG(0)
  ) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_b),
    .bus_io (b.master)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] sb[$];
  int         mh[2];
  int         mv[2];
  logic [7:0] m_uo[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_uo(input int h, input int v, input logic [5:0] c,
                                        input int ha, input int hf, input int hs,
                                        input int va, input int vf, input int vs,
                                        input logic neg);
    logic       hp, vp;
    logic [5:0] col;
    hp  = ((h >= ha + hf) && (h < ha + hf + hs)) ^ neg;
    vp  = ((v >= va + vf) && (v < va + vf + vs)) ^ neg;
    col = ((h < ha) && (v < va)) ? c : 6'd0;
    return {hp, col[0], col[2], col[4], vp, col[1], col[3], col[5]};
  endfunction

  // One clock of stimulus on instance sel (0: default 640x480, 1: small build).
  task automatic step(input int sel, input logic e, input logic [5:0] c);
    int ha, hf, hs, hb, va, vf, vs, vb, ht, vt;
    logic neg;
    logic [7:0] exp_u, o_u;
    logic [9:0] o_h, o_v;
    logic o_d, o_l, o_f;
    if (sel == 0) begin
      ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; neg = 1'b1;
      a.ena = e; a.rgb = c;
    end else begin
      ha = 8; hf = 2; hs = 3; hb = 2; va = 6; vf = 1; vs = 2; vb = 1; neg = 1'b0;
      b.ena = e; b.rgb = c;
    end
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (e) begin
      m_uo[sel] = exp_uo(mh[sel], mv[sel], c, ha, hf, hs, va, vf, vs, neg);
      if (mh[sel] == ht - 1) begin
        mh[sel] = 0;
        mv[sel] = (mv[sel] == vt - 1) ? 0 : mv[sel] + 1;
      end else begin
        mh[sel] = mh[sel] + 1;
      end
    end
    sb.push_back(m_uo[sel]);
    @(posedge clk);
    #1;
    exp_u = sb.pop_front();
    if (sel == 0) begin
      o_u = a.uo_out; o_h = a.hpos; o_v = a.vpos;
      o_d = a.display_on; o_l = a.line_end; o_f = a.frame_end;
    end else begin
      o_u = b.uo_out; o_h = b.hpos; o_v = b.vpos;
      o_d = b.display_on; o_l = b.line_end; o_f = b.frame_end;
    end
    chk("uo_out", 32'(o_u), 32'(exp_u));
    chk("hpos", 32'(o_h), 32'(mh[sel]));
    chk("vpos", 32'(o_v), 32'(mv[sel]));
    chk("display_on", 32'(o_d), 32'((mh[sel] < ha) && (mv[sel] < va)));
    chk("line_end", 32'(o_l), 32'(mh[sel] == ht - 1));
    chk("frame_end", 32'(o_f), 32'((mh[sel] == ht - 1) && (mv[sel] == vt - 1)));
  endtask

  initial begin
    int hs_low, hs_first, le_cnt, le_h;
    int fe_cnt, fe_last, fe_per, vs_hi, vs_fh, vs_fv, hs_fh;

    a.ena = 1'b0; a.rgb = '0;
    b.ena = 1'b0; b.rgb = '0;
    sb.delete();

    // Power-on reset state
    repeat (3) @(posedge clk);
    #1;
    chk("por_hpos", 32'(a.hpos), 32'd0);
    chk("por_vpos", 32'(a.vpos), 32'd0);
    chk("por_uo", 32'(a.uo_out), 32'h88);
    rst_a = 1'b1;
    mh[0] = 0; mv[0] = 0; m_uo[0] = 8'h88;

    repeat (300) step(0, 1'b1, 6'($urandom));

    // Asynchronous reset mid-line
    #3 rst_a = 1'b0;
    #1;
    chk("async_rst_hpos", 32'(a.hpos), 32'd0);
    chk("async_rst_vpos", 32'(a.vpos), 32'd0);
    chk("async_rst_uo", 32'(a.uo_out), 32'h88);
    a.ena = 1'b1; a.rgb = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_hpos", 32'(a.hpos), 32'd0);
      chk("rst_hold_uo", 32'(a.uo_out), 32'h88);
    end
    rst_a = 1'b1;
    sb.delete();
    mh[0] = 0; mv[0] = 0; m_uo[0] = 8'h88;

    // Line 0 in full white
    hs_low = 0; hs_first = -1; le_cnt = 0; le_h = -1;
    step(0, 1'b1, 6'h3F);
    chk("pix00_uo", 32'(a.uo_out), 32'hFF);
    while (mh[0] != 0) begin
      step(0, 1'b1, 6'h3F);
      if (mh[0] == 641) chk("blank641_uo", 32'(a.uo_out), 32'h88);
      if (a.uo_out[7] == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = mh[0];
      end
      if (a.line_end) begin
        le_cnt++;
        le_h = int'(a.hpos);
      end
    end
    chk("hsync_low_cycles", 32'(hs_low), 32'd96);
    chk("hsync_first_hpos", 32'(hs_first), 32'd657);
    chk("line_end_count", 32'(le_cnt), 32'd1);
    chk("line_end_hpos", 32'(le_h), 32'd799);
    chk("line1_vpos", 32'(a.vpos), 32'd1);

    // Line 1 with random colour, then stop at hpos=100 of line 2
    repeat (800) step(0, 1'b1, 6'($urandom));
    while (mh[0] != 100) step(0, 1'b1, 6'($urandom));

    // Freeze
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b0, 6'($urandom));
      chk("freeze_hpos", 32'(a.hpos), 32'd100);
      chk("freeze_vpos", 32'(a.vpos), 32'd2);
    end
    step(0, 1'b1, 6'($urandom));
    chk("resume_hpos", 32'(a.hpos), 32'd101);

    // Small build with active-high syncs
    a.ena = 1'b0;
    #1;
    chk("b_rst_uo", 32'(b.uo_out), 32'h00);
    rst_b = 1'b1;
    mh[1] = 0; mv[1] = 0; m_uo[1] = 8'h00;
    sb.delete();
    fe_cnt = 0; fe_last = -1; fe_per = -1;
    vs_hi = 0; vs_fh = -1; vs_fv = -1; hs_fh = -1;
    for (int i = 0; i < 305; i++) begin
      step(1, 1'b1, 6'($urandom));
      if (b.frame_end) begin
        fe_cnt++;
        if (fe_last >= 0) fe_per = i - fe_last;
        fe_last = i;
      end
      if (b.uo_out[3]) begin
        vs_hi++;
        if (vs_fh < 0) begin vs_fh = mh[1]; vs_fv = mv[1]; end
      end
      if (b.uo_out[7] && hs_fh < 0) hs_fh = mh[1];
    end
    chk("b_frame_end_count", 32'(fe_cnt), 32'd2);
    chk("b_frame_period", 32'(fe_per), 32'd150);
    chk("b_vsync_cycles", 32'(vs_hi), 32'd60);
    chk("b_vsync_first_h", 32'(vs_fh), 32'd1);
    chk("b_vsync_first_v", 32'(vs_fv), 32'd7);
    chk("b_hsync_first_h", 32'(hs_fh), 32'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
